// File: rtl/seq_div.sv
// Sequential restoring divider, WIDTH+2 cycle fixed latency, signed/unsigned.
// Ports: Clock, Reset, x, y, Sign, Start -> Hi (rem), Lo (quot), Ready, DivZero.
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             Sign,
  input  logic             Start,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Ready,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic             last_start;
  logic             accept;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] xs;
  logic             negq;
  logic             negr;
  logic             dz;

  logic [WIDTH-1:0] mag_x;
  logic [WIDTH-1:0] mag_y;
  logic [WIDTH:0]   shf;
  logic [WIDTH:0]   dif;

  assign accept = Start & ~last_start;

  assign mag_x = (Sign & x[WIDTH-1]) ? -x : x;
  assign mag_y = (Sign & y[WIDTH-1]) ? -y : y;

  // One extra bit keeps the trial subtraction from overflowing;
  // dif[WIDTH] set means the divisor did not fit.
  assign shf = {rem, quo[WIDTH-1]};
  assign dif = shf - {1'b0, dvs};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // RUN spends WIDTH step edges plus one hand-off edge, which
  // gives a result on edge N+WIDTH+2.
  always_comb begin
    state_nx = state;
    if (accept) begin
      state_nx = RUN;
    end else begin
      unique case (state)
        IDLE: state_nx = IDLE;
        RUN:  state_nx = (cnt == CW'(WIDTH)) ? FIX : RUN;
        FIX:  state_nx = DONE;
        DONE: state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      last_start <= 1'b0;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      xs         <= '0;
      negq       <= 1'b0;
      negr       <= 1'b0;
      dz         <= 1'b0;
      Hi         <= '0;
      Lo         <= '0;
      Ready      <= 1'b0;
      DivZero    <= 1'b0;
    end else begin
      last_start <= Start;
      if (accept) begin
        cnt     <= '0;
        rem     <= '0;
        quo     <= mag_x;
        dvs     <= mag_y;
        xs      <= x;
        negq    <= Sign & (x[WIDTH-1] ^ y[WIDTH-1]);
        negr    <= Sign & x[WIDTH-1];
        dz      <= (y == '0);
        Ready   <= 1'b0;
        DivZero <= 1'b0;
      end else begin
        unique case (state)
          RUN: begin
            if (cnt != CW'(WIDTH)) begin
              cnt <= cnt + 1'b1;
              if (!dif[WIDTH]) begin
                rem <= dif[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
              end else begin
                rem <= shf[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
              end
            end
          end
          FIX: begin
            // Divide by zero returns the untouched dividend as remainder.
            if (dz) begin
              Lo <= '1;
              Hi <= xs;
            end else begin
              Lo <= negq ? -quo : quo;
              Hi <= negr ? -rem : rem;
            end
            Ready   <= 1'b1;
            DivZero <= dz;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH=32).
// Checks latency, signed/unsigned results, div-by-zero, restart, reset.
module tb_seq_div;

  logic        Clock;
  logic        Reset;
  logic [31:0] x;
  logic [31:0] y;
  logic        Sign;
  logic        Start;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Ready;
  logic        DivZero;

  int checks;
  int failures;

  seq_div #(.WIDTH(32)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .x       (x),
    .y       (y),
    .Sign    (Sign),
    .Start   (Start),
    .Hi      (Hi),
    .Lo      (Lo),
    .Ready   (Ready),
    .DivZero (DivZero)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after edge N has been sampled; walks edges
  // from+1..33 expecting Ready low, then checks edge N+34.
  task automatic finish_op(input int from, input string tag,
                           input logic [31:0] elo,
                           input logic [31:0] ehi,
                           input logic edz);
    for (int k = from + 1; k <= 33; k++) begin
      @(posedge Clock);
      #1;
      chk({tag, "_busy"}, {63'd0, Ready}, 64'd0);
    end
    @(posedge Clock);
    #1;
    chk({tag, "_rdy"}, {63'd0, Ready}, 64'd1);
    chk({tag, "_lo"}, {32'd0, Lo}, {32'd0, elo});
    chk({tag, "_hi"}, {32'd0, Hi}, {32'd0, ehi});
    chk({tag, "_dz"}, {63'd0, DivZero}, {63'd0, edz});
  endtask

  task automatic launch(input logic s, input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge Clock);
    Sign  = s;
    x     = a;
    y     = b;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    chk("acc_rdy", {63'd0, Ready}, 64'd0);
    chk("acc_dz", {63'd0, DivZero}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi,
                        input logic edz);
    launch(s, a, b);
    finish_op(0, tag, elo, ehi, edz);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset = 1'b0;
    Start = 1'b0;
    Sign  = 1'b0;
    x     = '0;
    y     = '0;
    #2 Reset = 1'b1;
    #1;
    chk("rst_out", {Hi, Lo}, 64'd0);
    chk("rst_flags", {62'd0, Ready, DivZero}, 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    chk("idle_out", {Hi, Lo}, 64'd0);
    chk("idle_rdy", {63'd0, Ready}, 64'd0);

    run_op("s_100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (3) @(posedge Clock);
    #1;
    chk("hold_lo", {32'd0, Lo}, 64'd14);
    chk("hold_rdy", {63'd0, Ready}, 64'd1);

    run_op("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7,
           32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    run_op("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9,
           32'hFFFF_FFF2, 32'd2, 1'b0);
    run_op("u_ff_16", 1'b0, 32'hFFFF_FFFF, 32'd16,
           32'h0FFF_FFFF, 32'h0000_000F, 1'b0);
    run_op("s_ff_16", 1'b1, 32'hFFFF_FFFF, 32'd16,
           32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("u_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("s_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    run_op("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 32'd0, 1'b0);
    run_op("u_min_ff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 1'b0);
    run_op("u_big", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0);

    // Start held five cycles; operands change on the third.
    @(negedge Clock);
    Sign  = 1'b1;
    x     = 32'd100;
    y     = 32'd7;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    chk("held_acc", {63'd0, Ready}, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clock);
      if (k == 2) begin
        x    = 32'd50;
        y    = 32'd3;
        Sign = 1'b0;
      end
      @(posedge Clock);
      #1;
      chk("held_busy", {63'd0, Ready}, 64'd0);
    end
    Start = 1'b0;
    finish_op(4, "held", 32'd14, 32'd2, 1'b0);
    repeat (6) @(posedge Clock);
    #1;
    chk("held_once", {Ready, Hi, Lo[30:0]}, {1'b1, 32'd2, 31'd14});

    // Restart mid-operation at N+10.
    launch(1'b0, 32'd20, 32'd3);
    repeat (9) begin
      @(posedge Clock);
      #1;
      chk("rs_busy0", {63'd0, Ready}, 64'd0);
    end
    run_op("restart", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0);

    // Asynchronous reset between edges after N+12.
    launch(1'b1, 32'd100, 32'd7);
    repeat (12) @(posedge Clock);
    #3;
    Reset = 1'b1;
    #1;
    chk("mid_rst_out", {Hi, Lo}, 64'd0);
    chk("mid_rst_flags", {62'd0, Ready, DivZero}, 64'd0);
    @(negedge Clock);
    Reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clock);
      #1;
      chk("post_rst", {Hi, Lo}, 64'd0);
      chk("post_rst_f", {62'd0, Ready, DivZero}, 64'd0);
    end

    // Start already high when reset releases.
    @(negedge Clock);
    Reset = 1'b1;
    Sign  = 1'b0;
    x     = 32'd5;
    y     = 32'd0;
    Start = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    chk("rel_acc", {63'd0, Ready}, 64'd0);
    finish_op(0, "rel_start", 32'hFFFF_FFFF, 32'd5, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
